fractal_sync_rx: RTL and testbench
==================================

FRACTAL_SYNC_RX -- requirements
Module: fractal_sync_rx

Interface
REQ-001 SHALL have parameter N_PORTS, default 2, giving the number of child request ports (1 or 2).
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, giving the per-port buffer entries (power of two, >=1).
REQ-003 SHALL have parameter LVL_W, default 4, giving the width of the sync-level field.
REQ-004 SHALL have parameter ID_W, default 8, giving the width of the barrier-id field.
REQ-005 SHALL have clk_i, input, 1 bit, the single clock; all state SHALL be updated on its rising edge.
REQ-006 SHALL have rst_i, input, 1 bit, a synchronous active-high reset.
REQ-007 SHALL have req_valid_i, input, N_PORTS bits, per-port request valid.
REQ-008 SHALL have req_i, input, N_PORTS x fsync_req_t, per-port request {aggr (1), lvl (LVL_W), id (ID_W)}.
REQ-009 SHALL have req_ready_o, output, N_PORTS bits, per-port accept.
REQ-010 SHALL have out_valid_o, output, 1 bit, stating that a request is offered downstream.
REQ-011 SHALL have out_req_o, output, fsync_req_t, the offered request.
REQ-012 SHALL have out_port_o, output, N_PORTS bits, a one-hot (or two-hot when paired) source mask.
REQ-013 SHALL have out_pair_o, output, 1 bit, stating that the offered request merges identical heads of both ports.
REQ-014 SHALL have out_ready_i, input, 1 bit, the downstream accept.

Function
REQ-015 SHALL transfer an input beat when req_valid_i[p] && req_ready_o[p]; it SHALL push into FIFO p.
REQ-016 SHALL drive req_ready_o[p] high iff FIFO p count < FIFO_DEPTH; there SHALL be no combinational path from out_ready_i or req_valid_i to req_ready_o.
REQ-017 SHALL make a pushed entry visible at the FIFO head no earlier than the next cycle; minimum input-to-out_valid_o latency SHALL be 1 cycle.
REQ-018 SHALL treat push and pop on the same FIFO in the same cycle as legal at any count except full-push (blocked by REQ-016); the count SHALL stay unchanged.
REQ-019 SHALL wrap read/write pointers modulo FIFO_DEPTH; count SHALL be $clog2(FIFO_DEPTH)+1 bits wide.
REQ-020 SHALL run a 2-state FSM: IDLE (nothing offered or choosing) and HOLD (offer stalled).
REQ-021 SHALL, in IDLE, when N_PORTS==2, both heads are valid, and lvl and id are equal, offer a pair: out_pair_o=1, out_port_o=2'b11, out_req_o=port-0 head with aggr = OR of both aggr bits.
REQ-022 SHALL, in IDLE otherwise, grant round-robin among non-empty heads starting at rr_ptr: out_pair_o=0, out_port_o one-hot.
REQ-023 SHALL, on a handshake (out_valid_o && out_ready_i), pop the granted FIFO(s); for a single grant, rr_ptr SHALL move to the port after the granted one; for a pair, rr_ptr SHALL be unchanged.
REQ-024 SHALL, when out_valid_o && !out_ready_i, enter HOLD with the grant latched.
REQ-025 SHALL, in HOLD, keep out_req_o, out_port_o and out_pair_o stable until the handshake, even if a pair becomes available; on the handshake it SHALL return to IDLE.
REQ-026 SHALL keep out_valid_o from deasserting without a handshake.

Reset
REQ-027 SHALL, while rst_i=1 at a clock edge, clear all FIFO pointers and counts, set rr_ptr=0 and FSM=IDLE, and discard buffered entries and any latched grant.
REQ-028 SHALL hold out_valid_o=0, out_pair_o=0, out_port_o=0, out_req_o=0 and req_ready_o=0 during reset; req_ready_o SHALL go all-ones in the first cycle after reset release.
REQ-029 SHALL drop any held offer when reset is asserted mid-operation, with no pop reported.

Structure
REQ-030 SHALL define fsync_req_t, the FSM state enum and the default widths in fractal_sync_pkg.
REQ-031 SHALL instantiate one sub-module per port, fractal_sync_rx_fifo (synchronous FIFO with count, full, empty and head); arbitration and the FSM SHALL be in the top module.

Verification
REQ-032 SHALL cover single-port latency: port0 sends {0,3,0x15} at cycle 0 with out_ready_i=1 -> out_valid_o=1 at cycle 1, out_port_o=01, out_pair_o=0.
REQ-033 SHALL cover pairing: both ports send lvl=2, id=0x07, aggr 0 and 1 in the same cycle -> one beat with out_pair_o=1, out_port_o=11, aggr=1, and both FIFOs empty afterwards.
REQ-034 SHALL cover round-robin: both ports stream mismatched ids with out_ready_i=1 -> grants alternate 01,10,01,10 starting at port 0 after reset.
REQ-035 SHALL cover backpressure/full: out_ready_i=0 while port0 pushes 3 beats with FIFO_DEPTH=2 -> req_ready_o[0]=0 after 2 accepts, the out signals stay stable, and the third beat is accepted only after a pop.
REQ-036 SHALL cover the HOLD lock: a single grant from port0 is stalled, then a matching port1 head arrives -> the offer stays single (01) until the handshake, then the next offer pairs the remaining entries if they match.
REQ-037 SHALL cover mid-operation reset: rst_i pulses for 1 cycle while holding 2 entries -> out_valid_o=0 the next cycle and no stale entry is emitted.

Source files
------------

// File: rtl/fractal_sync_pkg.sv
// Shared types for the fractal sync receive path: request beat layout, FSM
// states, default widths and the barrier-match helper.
package fractal_sync_pkg;

  localparam int unsigned FSYNC_N_PORTS    = 2;
  localparam int unsigned FSYNC_FIFO_DEPTH = 2;
  localparam int unsigned FSYNC_LVL_W      = 4;
  localparam int unsigned FSYNC_ID_W       = 8;

  typedef struct packed {
    logic                   aggr;
    logic [FSYNC_LVL_W-1:0] lvl;
    logic [FSYNC_ID_W-1:0]  id;
  } fsync_req_t;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_HOLD = 1'b1
  } fsync_rx_state_e;

  // Two requests refer to the same barrier when level and id agree; aggr is merged.
  function automatic logic same_barrier(input fsync_req_t a, input fsync_req_t b);
    return (a.lvl == b.lvl) && (a.id == b.id);
  endfunction

endpackage

// File: rtl/fractal_sync_rx_fifo.sv
// Per-port synchronous FIFO with count/full/empty and a registered head; a push is
// visible at the head the next cycle. Pushes when full and pops when empty are ignored.
module fractal_sync_rx_fifo #(
  parameter int unsigned DATA_W = 13,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [DATA_W-1:0]      dat_i,
  input  logic                   pop_i,
  output logic [DATA_W-1:0]      head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = dat_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/fractal_sync_rx.sv
// Buffers child sync requests per port and offers one (or a merged pair) downstream;
// 1 cycle input-to-offer, ready = per-port FIFO not full, a stalled offer is frozen.
module fractal_sync_rx
  import fractal_sync_pkg::*;
#(
  parameter int unsigned N_PORTS    = FSYNC_N_PORTS,
  parameter int unsigned FIFO_DEPTH = FSYNC_FIFO_DEPTH,
  parameter int unsigned LVL_W      = FSYNC_LVL_W,
  parameter int unsigned ID_W       = FSYNC_ID_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_PORTS-1:0]       req_valid_i,
  input  fsync_req_t [N_PORTS-1:0] req_i,
  output logic [N_PORTS-1:0]       req_ready_o,
  output logic                     out_valid_o,
  output fsync_req_t               out_req_o,
  output logic [N_PORTS-1:0]       out_port_o,
  output logic                     out_pair_o,
  input  logic                     out_ready_i
);

  localparam int unsigned RR_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  if (LVL_W != FSYNC_LVL_W || ID_W != FSYNC_ID_W || N_PORTS < 1 || N_PORTS > 2) begin : g_param_chk
    $error("fractal_sync_rx: N_PORTS must be 1..2 and LVL_W/ID_W must match fractal_sync_pkg");
  end

  fsync_req_t         head [N_PORTS];
  logic [CNT_W-1:0]   fifo_cnt [N_PORTS];
  logic [N_PORTS-1:0] fifo_empty;
  logic [N_PORTS-1:0] unused_full;
  logic [N_PORTS-1:0] head_vld;
  logic [N_PORTS-1:0] pop;

  fsync_rx_state_e    state_q, state_d;
  logic [RR_W-1:0]    rr_q, rr_d;
  fsync_req_t         hold_req_q, hold_req_d;
  logic [N_PORTS-1:0] hold_port_q, hold_port_d;
  logic               hold_pair_q, hold_pair_d;

  logic               pair_ok, any_vld, hs;
  fsync_req_t         sel_req;
  logic [N_PORTS-1:0] sel_port;
  logic               sel_pair;
  logic [RR_W-1:0]    sel_idx, gnt_idx;

  for (genvar p = 0; p < int'(N_PORTS); p++) begin : g_port
    assign req_ready_o[p] = !rst_i && (fifo_cnt[p] < CNT_W'(FIFO_DEPTH));
    assign head_vld[p]    = !fifo_empty[p];

    fractal_sync_rx_fifo #(
      .DATA_W ($bits(fsync_req_t)),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (req_valid_i[p] && req_ready_o[p]),
      .dat_i   (req_i[p]),
      .pop_i   (pop[p]),
      .head_o  (head[p]),
      .count_o (fifo_cnt[p]),
      .full_o  (unused_full[p]),
      .empty_o (fifo_empty[p])
    );
  end

  // Candidate offer: a merged pair wins over round-robin when both heads name one barrier.
  always_comb begin
    int   idx;
    logic found;
    idx      = 0;
    found    = 1'b0;
    sel_idx  = '0;
    sel_req  = '0;
    sel_port = '0;
    sel_pair = 1'b0;
    any_vld  = |head_vld;
    pair_ok  = (N_PORTS == 2) && head_vld[0] && head_vld[N_PORTS-1] &&
               same_barrier(head[0], head[N_PORTS-1]);
    for (int k = 0; k < int'(N_PORTS); k++) begin
      idx = (int'(rr_q) + k) % int'(N_PORTS);
      if (!found && head_vld[idx]) begin
        found   = 1'b1;
        sel_idx = RR_W'(idx);
      end
    end
    if (pair_ok) begin
      sel_pair     = 1'b1;
      sel_port     = '1;
      sel_req      = head[0];
      sel_req.aggr = head[0].aggr | head[N_PORTS-1].aggr;
    end else if (any_vld) begin
      sel_port[sel_idx] = 1'b1;
      sel_req           = head[sel_idx];
    end
  end

  always_comb begin
    out_valid_o = 1'b0;
    out_req_o   = '0;
    out_port_o  = '0;
    out_pair_o  = 1'b0;
    if (!rst_i) begin
      if (state_q == RX_HOLD) begin
        out_valid_o = 1'b1;
        out_req_o   = hold_req_q;
        out_port_o  = hold_port_q;
        out_pair_o  = hold_pair_q;
      end else begin
        out_valid_o = any_vld;
        out_req_o   = sel_req;
        out_port_o  = sel_port;
        out_pair_o  = sel_pair;
      end
    end
  end

  always_comb begin
    hs          = out_valid_o && out_ready_i;
    pop         = hs ? out_port_o : '0;
    gnt_idx     = '0;
    state_d     = state_q;
    rr_d        = rr_q;
    hold_req_d  = hold_req_q;
    hold_port_d = hold_port_q;
    hold_pair_d = hold_pair_q;
    for (int p = 0; p < int'(N_PORTS); p++) begin
      if (out_port_o[p]) gnt_idx = RR_W'(p);
    end
    case (state_q)
      RX_IDLE: begin
        if (out_valid_o && !out_ready_i) begin
          state_d     = RX_HOLD;
          hold_req_d  = sel_req;
          hold_port_d = sel_port;
          hold_pair_d = sel_pair;
        end
      end
      RX_HOLD: begin
        if (hs) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
    if (hs && !out_pair_o) begin
      rr_d = (int'(gnt_idx) == int'(N_PORTS) - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RX_IDLE;
      rr_q        <= '0;
      hold_req_q  <= '0;
      hold_port_q <= '0;
      hold_pair_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      hold_req_q  <= hold_req_d;
      hold_port_q <= hold_port_d;
      hold_pair_q <= hold_pair_d;
    end
  end

endmodule

// File: tb/tb_fractal_sync_rx.sv
// Self-checking bench: vector table plus hand sequences, with a scoreboard of
// expected downstream beats compared whenever the DUT completes a handshake.
module tb_fractal_sync_rx;
  import fractal_sync_pkg::*;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [1:0]       req_valid_i;
  fsync_req_t [1:0] req_i;
  logic [1:0]       req_ready_o;
  logic             out_valid_o;
  fsync_req_t       out_req_o;
  logic [1:0]       out_port_o;
  logic             out_pair_o;
  logic             out_ready_i;

  always #5 clk_i = ~clk_i;

  fractal_sync_rx #(
    .N_PORTS(2), .FIFO_DEPTH(2), .LVL_W(4), .ID_W(8)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_i       (req_i),
    .req_ready_o (req_ready_o),
    .out_valid_o (out_valid_o),
    .out_req_o   (out_req_o),
    .out_port_o  (out_port_o),
    .out_pair_o  (out_pair_o),
    .out_ready_i (out_ready_i)
  );

  typedef struct packed {
    fsync_req_t req;
    logic [1:0] port;
    logic       pair;
  } beat_t;

  typedef struct {
    logic [1:0] vld;
    fsync_req_t r0;
    fsync_req_t r1;
    int         n;
    beat_t      b0;
    beat_t      b1;
  } vec_t;

  int    total = 0;
  int    bad   = 0;
  beat_t exp_q[$];
  beat_t mon_e;
  vec_t  tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic fsync_req_t mk(input logic a, input logic [3:0] l, input logic [7:0] i);
    return {a, l, i};
  endfunction

  function automatic beat_t bt(input fsync_req_t r, input logic [1:0] p, input logic pr);
    return {r, p, pr};
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Scoreboard: a beat is taken at the next rising edge when valid&ready at the falling edge.
  always @(negedge clk_i) begin
    if (!rst_i && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra: got port=%b pair=%b req=%h, expected no beat",
                 out_port_o, out_pair_o, out_req_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_req",  32'(out_req_o),  32'(mon_e.req));
        chk("sb_port", 32'(out_port_o), 32'(mon_e.port));
        chk("sb_pair", 32'(out_pair_o), 32'(mon_e.pair));
      end
    end
  end

  task automatic do_reset(input string name);
    rst_i       = 1'b1;
    req_valid_i = '0;
    req_i       = '0;
    out_ready_i = 1'b0;
    step();
    chk($sformatf("%s_rst_vld", name),  32'(out_valid_o), 32'd0);
    chk($sformatf("%s_rst_port", name), 32'(out_port_o),  32'd0);
    chk($sformatf("%s_rst_pair", name), 32'(out_pair_o),  32'd0);
    chk($sformatf("%s_rst_req", name),  32'(out_req_o),   32'd0);
    chk($sformatf("%s_rst_rdy", name),  32'(req_ready_o), 32'd0);
    rst_i = 1'b0;
    #1;
    chk($sformatf("%s_rel_rdy", name), 32'(req_ready_o), 32'h3);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid_o) && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) begin
      total++;
      bad++;
      $display("FAIL %s_drain: timeout with %0d beats outstanding, valid=%b", name, exp_q.size(), out_valid_o);
    end
    chk($sformatf("%s_idle", name), 32'(out_valid_o), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    fsync_req_t a, b, c, d, x1, x2, x3, y, z;

    // vld, r0, r1, beats, first beat, second beat (round-robin pointer tracked by hand)
    tbl[0] = '{2'b11, mk(0,2,8'h07), mk(1,2,8'h07), 1, bt(mk(1,2,8'h07),2'b11,1), '0};
    tbl[1] = '{2'b11, mk(0,1,8'h10), mk(0,1,8'h11), 2, bt(mk(0,1,8'h10),2'b01,0), bt(mk(0,1,8'h11),2'b10,0)};
    tbl[2] = '{2'b10, mk(0,0,8'h00), mk(1,5,8'h33), 1, bt(mk(1,5,8'h33),2'b10,0), '0};
    tbl[3] = '{2'b11, mk(1,4,8'h20), mk(0,4,8'h21), 2, bt(mk(1,4,8'h20),2'b01,0), bt(mk(0,4,8'h21),2'b10,0)};
    tbl[4] = '{2'b11, mk(0,6,8'h40), mk(0,7,8'h40), 2, bt(mk(0,6,8'h40),2'b01,0), bt(mk(0,7,8'h40),2'b10,0)};
    tbl[5] = '{2'b01, mk(0,3,8'h15), mk(0,0,8'h00), 1, bt(mk(0,3,8'h15),2'b01,0), '0};
    tbl[6] = '{2'b11, mk(0,8,8'h50), mk(0,8,8'h51), 2, bt(mk(0,8,8'h51),2'b10,0), bt(mk(0,8,8'h50),2'b01,0)};
    tbl[7] = '{2'b11, mk(0,9,8'hAA), mk(0,9,8'hAA), 1, bt(mk(0,9,8'hAA),2'b11,1), '0};
    tbl[8] = '{2'b10, mk(0,0,8'h00), mk(1,1,8'h01), 1, bt(mk(1,1,8'h01),2'b10,0), '0};

    // Single-port latency
    do_reset("lat");
    out_ready_i = 1'b1;
    req_valid_i = 2'b01;
    req_i[0]    = mk(0, 3, 8'h15);
    exp_q.push_back(bt(mk(0,3,8'h15), 2'b01, 1'b0));
    #1;
    chk("lat_c0_vld", 32'(out_valid_o), 32'd0);
    step();
    req_valid_i = 2'b00;
    chk("lat_c1_vld",  32'(out_valid_o), 32'd1);
    chk("lat_c1_port", 32'(out_port_o),  32'h1);
    chk("lat_c1_pair", 32'(out_pair_o),  32'd0);
    step();
    chk("lat_c2_vld", 32'(out_valid_o), 32'd0);

    // Vector table: one simultaneous push per record, drained with out_ready_i high
    do_reset("tbl");
    for (int i = 0; i < 9; i++) begin
      req_valid_i = tbl[i].vld;
      req_i[0]    = tbl[i].r0;
      req_i[1]    = tbl[i].r1;
      out_ready_i = 1'b1;
      exp_q.push_back(tbl[i].b0);
      if (tbl[i].n == 2) exp_q.push_back(tbl[i].b1);
      #1;
      chk($sformatf("vec%0d_rdy", i), 32'(req_ready_o), 32'h3);
      step();
      req_valid_i = 2'b00;
      drain($sformatf("vec%0d", i));
    end

    // Round-robin stream from reset: grants 01,10,01,10
    do_reset("rr");
    a = mk(0,1,8'h01); b = mk(0,1,8'h02); c = mk(0,1,8'h03); d = mk(0,1,8'h04);
    exp_q.push_back(bt(a, 2'b01, 0));
    exp_q.push_back(bt(b, 2'b10, 0));
    exp_q.push_back(bt(c, 2'b01, 0));
    exp_q.push_back(bt(d, 2'b10, 0));
    out_ready_i = 1'b1;
    req_valid_i = 2'b11;
    req_i[0] = a; req_i[1] = b;
    step();
    chk("rr_rdy", 32'(req_ready_o), 32'h3);
    req_i[0] = c; req_i[1] = d;
    step();
    req_valid_i = 2'b00;
    drain("rr");

    // Backpressure and full FIFO on port 0
    do_reset("bp");
    x1 = mk(0,1,8'h61); x2 = mk(0,1,8'h62); x3 = mk(1,1,8'h63);
    exp_q.push_back(bt(x1, 2'b01, 0));
    exp_q.push_back(bt(x2, 2'b01, 0));
    exp_q.push_back(bt(x3, 2'b01, 0));
    out_ready_i = 1'b0;
    req_valid_i = 2'b01;
    req_i[0]    = x1;
    step();
    chk("bp_rdy_one", 32'(req_ready_o[0]), 32'd1);
    req_i[0] = x2;
    step();
    chk("bp_rdy_full", 32'(req_ready_o[0]), 32'd0);
    req_i[0] = x3;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_hold%0d_vld", k),  32'(out_valid_o), 32'd1);
      chk($sformatf("bp_hold%0d_req", k),  32'(out_req_o),   32'(x1));
      chk($sformatf("bp_hold%0d_port", k), 32'(out_port_o),  32'h1);
      chk($sformatf("bp_hold%0d_rdy", k),  32'(req_ready_o[0]), 32'd0);
      step();
    end
    out_ready_i = 1'b1;
    #1;
    chk("bp_pop_cycle_rdy", 32'(req_ready_o[0]), 32'd0);
    step();
    chk("bp_after_pop_rdy", 32'(req_ready_o[0]), 32'd1);
    step();
    req_valid_i = 2'b00;
    drain("bp");

    // HOLD keeps a single grant even when a matching pair appears
    do_reset("hl");
    y = mk(0,2,8'h30); z = mk(1,2,8'h30);
    exp_q.push_back(bt(y, 2'b01, 0));
    exp_q.push_back(bt(mk(1,2,8'h30), 2'b11, 1));
    out_ready_i = 1'b0;
    req_valid_i = 2'b01;
    req_i[0]    = y;
    step();
    req_valid_i = 2'b11;
    req_i[1]    = z;
    chk("hl_c1_port", 32'(out_port_o), 32'h1);
    step();
    req_valid_i = 2'b00;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("hl_lock%0d_port", k), 32'(out_port_o), 32'h1);
      chk($sformatf("hl_lock%0d_pair", k), 32'(out_pair_o), 32'd0);
      chk($sformatf("hl_lock%0d_req", k),  32'(out_req_o),  32'(y));
      step();
    end
    out_ready_i = 1'b1;
    step();
    chk("hl_pair_vld",  32'(out_valid_o), 32'd1);
    chk("hl_pair_port", 32'(out_port_o),  32'h3);
    chk("hl_pair_flag", 32'(out_pair_o),  32'd1);
    drain("hl");

    // Reset pulse while an offer is held and two entries are buffered
    out_ready_i = 1'b0;
    req_valid_i = 2'b11;
    req_i[0]    = mk(0,5,8'h71);
    req_i[1]    = mk(0,5,8'h72);
    step();
    req_valid_i = 2'b00;
    step();
    chk("mr_pre_vld", 32'(out_valid_o), 32'd1);
    rst_i = 1'b1;
    #1;
    chk("mr_in_rst_vld", 32'(out_valid_o), 32'd0);
    chk("mr_in_rst_rdy", 32'(req_ready_o), 32'd0);
    step();
    rst_i = 1'b0;
    #1;
    chk("mr_post_vld", 32'(out_valid_o), 32'd0);
    chk("mr_post_rdy", 32'(req_ready_o), 32'h3);
    out_ready_i = 1'b1;
    step(4);
    chk("mr_quiet_vld", 32'(out_valid_o), 32'd0);

    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
